// File: rtl/dmem_axi_ctrl_pkg.sv
// Shared types and constants for the data-memory AXI4-Lite controller:
// widths, funct3 encodings, AXI response codes and FSM states.
package dmem_axi_ctrl_pkg;

  localparam int XLEN          = 32;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int STRB_BITS     = AXI_DATA_BITS / 8;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Unsigned encodings only exist for loads; anything unrecognised is a word.
  function automatic size_e access_size(input logic store, input logic [2:0] funct3);
    size_e sz;
    sz = SZ_W;
    case (funct3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_BU:   sz = store ? SZ_W : SZ_B;
      F3_HU:   sz = store ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: write strobes, store-data replication,
// load byte/halfword extraction with sign/zero extension, misalignment.
module lsu_align
  import dmem_axi_ctrl_pkg::*;
(
  input  logic                 store,
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata,
  output logic [STRB_BITS-1:0] wstrb,
  output logic [XLEN-1:0]      wdata_rep,
  output logic [XLEN-1:0]      rdata_ext,
  output logic                 misaligned
);

  size_e       size;
  logic        load_signed;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size        = access_size(store, funct3);
  assign load_signed = ~funct3[2];
  assign byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wstrb      = 4'b1111;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = {{24{load_signed & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext  = {{16{load_signed & half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      default: misaligned = |addr_lo;
    endcase
  end

  // Each byte lane carries the low byte, the matching halfword byte, or its own byte.
  generate
    for (genvar gi = 0; gi < STRB_BITS; gi++) begin : g_lane
      assign wdata_rep[gi*8 +: 8] = (size == SZ_B) ? wdata[7:0] :
                                    (size == SZ_H) ? wdata[(gi%2)*8 +: 8] :
                                                     wdata[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_axi_ctrl.sv
// MEM-stage load/store unit bridging one pipeline access at a time onto an
// AXI4-Lite master port; stalls the pipeline until the access completes.
module dmem_axi_ctrl #(
  parameter int XLEN          = dmem_axi_ctrl_pkg::XLEN,
  parameter int AXI_ADDR_BITS = dmem_axi_ctrl_pkg::AXI_ADDR_BITS,
  parameter int AXI_DATA_BITS = dmem_axi_ctrl_pkg::AXI_DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_ren_i,
  input  logic                       mem_wen_i,
  input  logic [XLEN-1:0]            mem_addr_i,
  input  logic [XLEN-1:0]            mem_wdata_i,
  input  logic [2:0]                 mem_funct3_i,
  output logic                       mem_stall_o,
  output logic [XLEN-1:0]            mem_rdata_o,
  output logic                       mem_rvalid_o,
  output logic                       mem_err_o,
  output logic [AXI_ADDR_BITS-1:0]   araddr_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  input  logic [AXI_DATA_BITS-1:0]   rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rvalid_i,
  output logic                       rready_o,
  output logic [AXI_ADDR_BITS-1:0]   awaddr_o,
  output logic                       awvalid_o,
  input  logic                       awready_i,
  output logic [AXI_DATA_BITS-1:0]   wdata_o,
  output logic [AXI_DATA_BITS/8-1:0] wstrb_o,
  output logic                       wvalid_o,
  input  logic                       wready_i,
  input  logic [1:0]                 bresp_i,
  input  logic                       bvalid_i,
  output logic                       bready_o
);

  import dmem_axi_ctrl_pkg::*;

  state_e                     state_reg;
  logic [XLEN-1:0]            addr_reg;
  logic [2:0]                 funct3_reg;
  logic                       store_reg;

  logic                       is_idle;
  logic                       req;
  logic                       sel_store;
  logic [1:0]                 sel_addr_lo;
  logic [2:0]                 sel_funct3;
  logic [AXI_DATA_BITS/8-1:0] align_wstrb;
  logic [XLEN-1:0]            align_wdata;
  logic [XLEN-1:0]            align_rdata;
  logic                       misaligned;
  logic                       aw_hs;
  logic                       w_hs;

  assign is_idle = (state_reg == S_IDLE);
  assign req     = mem_ren_i | mem_wen_i;

  assign mem_stall_o = is_idle ? req : (state_reg != S_DONE);

  assign araddr_o = {addr_reg[AXI_ADDR_BITS-1:2], 2'b00};
  assign awaddr_o = {addr_reg[AXI_ADDR_BITS-1:2], 2'b00};

  // The aligner looks at the live request in IDLE (to decide misalignment and
  // prepare W data), and at the latched request afterwards (for load extraction).
  assign sel_store   = is_idle ? mem_wen_i         : store_reg;
  assign sel_addr_lo = is_idle ? mem_addr_i[1:0]   : addr_reg[1:0];
  assign sel_funct3  = is_idle ? mem_funct3_i      : funct3_reg;

  lsu_align u_align (
    .store      (sel_store),
    .addr_lo    (sel_addr_lo),
    .funct3     (sel_funct3),
    .wdata      (mem_wdata_i),
    .rdata      (rdata_i),
    .wstrb      (align_wstrb),
    .wdata_rep  (align_wdata),
    .rdata_ext  (align_rdata),
    .misaligned (misaligned)
  );

  assign aw_hs = awvalid_o & awready_i;
  assign w_hs  = wvalid_o & wready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      funct3_reg   <= '0;
      store_reg    <= 1'b0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      awvalid_o    <= 1'b0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
      wdata_o      <= '0;
      wstrb_o      <= '0;
      mem_rdata_o  <= '0;
      mem_rvalid_o <= 1'b0;
      mem_err_o    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            addr_reg   <= mem_addr_i;
            funct3_reg <= mem_funct3_i;
            store_reg  <= mem_wen_i;
            if (misaligned) begin
              mem_err_o <= 1'b1;
              state_reg <= S_DONE;
            end else if (mem_wen_i) begin
              wdata_o   <= align_wdata;
              wstrb_o   <= align_wstrb;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              state_reg <= S_WR_REQ;
            end else begin
              arvalid_o <= 1'b1;
              state_reg <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state_reg <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid_i) begin
            rready_o     <= 1'b0;
            mem_rdata_o  <= align_rdata;
            mem_rvalid_o <= 1'b1;
            mem_err_o    <= (rresp_i != RESP_OKAY);
            state_reg    <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) awvalid_o <= 1'b0;
          if (w_hs)  wvalid_o  <= 1'b0;
          // A channel already handshaken has its valid low, so it counts as done.
          if ((aw_hs || !awvalid_o) && (w_hs || !wvalid_o)) begin
            bready_o  <= 1'b1;
            state_reg <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid_i) begin
            bready_o  <= 1'b0;
            mem_err_o <= (bresp_i != RESP_OKAY);
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          mem_rvalid_o <= 1'b0;
          mem_err_o    <= 1'b0;
          state_reg    <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_axi_ctrl.sv
// Randomised bench for dmem_axi_ctrl: the bench plays the AXI slave with
// random per-channel delays and checks against a byte-lane reference model.
module tb_dmem_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren_i = 1'b0, mem_wen_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic [2:0]  mem_funct3_i = '0;
  logic        mem_stall_o, mem_rvalid_o, mem_err_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] araddr_o, awaddr_o, wdata_o;
  logic        arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
  logic [3:0]  wstrb_o;
  logic        arready_i = 1'b0, rvalid_i = 1'b0, awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0, bresp_i = '0;

  int total = 0;
  int bad = 0;
  int txn_no = 0;

  dmem_axi_ctrl #(.XLEN(32), .AXI_ADDR_BITS(32), .AXI_DATA_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_funct3_i(mem_funct3_i),
    .mem_stall_o(mem_stall_o), .mem_rdata_o(mem_rdata_o),
    .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Access width in bytes; unsigned variants exist only for loads.
  function automatic int ref_size(input bit st, input bit [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return st ? 4 : 1;
      3'd5: return st ? 4 : 2;
      default: return 4;
    endcase
  endfunction

  function automatic int ref_off(input int sz, input bit [31:0] addr);
    return int'(addr[1:0]) & (4 - sz);
  endfunction

  function automatic bit [31:0] ref_strb(input int sz, input bit [31:0] addr);
    return ((32'd1 << sz) - 32'd1) << ref_off(sz, addr);
  endfunction

  function automatic bit [31:0] ref_wdata(input int sz, input bit [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit [31:0] ref_rdata(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] word);
    int sz;
    longint unsigned mask, v;
    sz   = ref_size(1'b0, f3);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = ({32'd0, word} >> (8 * ref_off(sz, addr))) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && (((v >> (8 * sz - 1)) & 64'd1) != 0))
      v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic run_txn(input bit st, input bit both, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] rd, input bit [1:0] resp,
                         input int ard, input int rdl, input int awd, input int wdl, input int bdl);
    int  sz, exp_lat, cyc;
    bit  mis, done, any_valid;
    bit  ar_done, aw_done, w_done, r_pend, b_pend, b_started;
    int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit  v_ar, v_aw, v_w, ar_hs, aw_hs, w_hs, r_hs, b_hs;
    sz  = ref_size(st, f3);
    mis = (int'(addr[1:0]) % sz) != 0;
    if (mis)     exp_lat = 1;
    else if (st) exp_lat = 1 + ((awd > wdl ? awd : wdl) + 1) + (bdl + 1);
    else         exp_lat = 1 + (ard + 1) + (rdl + 1);
    {ar_done, aw_done, w_done, r_pend, b_pend, b_started, done, any_valid} = '0;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
    cyc = 0;

    mem_wen_i    = st;
    mem_ren_i    = st ? both : 1'b1;
    mem_addr_i   = addr;
    mem_wdata_i  = wd;
    mem_funct3_i = f3;
    #1;
    chk("stall_on_req", mem_stall_o, 1);

    while (!done && cyc < 200) begin
      if (cyc > 0 && !mem_stall_o) begin
        done = 1'b1;
        chk("latency", cyc, exp_lat);
        chk("done_err", mem_err_o, (mis || resp != 2'b00) ? 1 : 0);
        if (!mis) chk("done_rvalid", mem_rvalid_o, st ? 0 : 1);
        if (!st && !mis) chk("load_data", mem_rdata_o, ref_rdata(f3, addr, rd));
        if (mis) chk("misaligned_no_axi", any_valid, 0);
      end else begin
        if (arvalid_o || awvalid_o || wvalid_o) any_valid = 1'b1;
        if (cyc > 0 && !mis) begin
          if (st) begin
            chk("awvalid_hold", awvalid_o, aw_done ? 0 : 1);
            chk("wvalid_hold", wvalid_o, w_done ? 0 : 1);
          end else begin
            chk("arvalid_hold", arvalid_o, ar_done ? 0 : 1);
          end
        end
        arready_i = arvalid_o && ar_cnt >= ard;
        awready_i = awvalid_o && aw_cnt >= awd;
        wready_i  = wvalid_o && w_cnt >= wdl;
        rvalid_i  = r_pend && r_cnt >= rdl;
        rdata_i   = rd;
        rresp_i   = resp;
        bvalid_i  = b_pend && b_cnt >= bdl;
        bresp_i   = resp;
        v_ar = arvalid_o; v_aw = awvalid_o; v_w = wvalid_o;
        ar_hs = arvalid_o && arready_i;
        aw_hs = awvalid_o && awready_i;
        w_hs  = wvalid_o && wready_i;
        r_hs  = rvalid_i && rready_o;
        b_hs  = bvalid_i && bready_o;
        if (ar_hs) chk("araddr", araddr_o, addr & 32'hFFFF_FFFC);
        if (aw_hs) chk("awaddr", awaddr_o, addr & 32'hFFFF_FFFC);
        if (w_hs) begin
          chk("wstrb", {28'd0, wstrb_o}, ref_strb(sz, addr));
          chk("wdata", wdata_o, ref_wdata(sz, wd));
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_ren_i = 1'b0;
        mem_wen_i = 1'b0;
        if (r_hs) r_pend = 1'b0; else if (r_pend) r_cnt++;
        if (ar_hs) begin ar_done = 1'b1; r_pend = 1'b1; end else if (v_ar) ar_cnt++;
        if (aw_hs) aw_done = 1'b1; else if (v_aw) aw_cnt++;
        if (w_hs) w_done = 1'b1; else if (v_w) w_cnt++;
        if (b_hs) b_pend = 1'b0; else if (b_pend) b_cnt++;
        if (aw_done && w_done && !b_started) begin b_started = 1'b1; b_pend = 1'b1; end
      end
    end
    if (!done) chk("timeout", 0, 1);
    {arready_i, awready_i, wready_i, rvalid_i, bvalid_i} = '0;
    $display("txn %0d %s f3=%0d addr=%h wd=%h rd=%h resp=%0d lat=%0d rdata_o=%h err=%0b",
             txn_no, st ? "ST" : "LD", f3, addr, wd, rd, resp, cyc, mem_rdata_o, mem_err_o);
    txn_no++;
    @(posedge clk);
    #1;
    chk("idle_rvalid", mem_rvalid_o, 0);
    chk("idle_err", mem_err_o, 0);
    chk("idle_stall", mem_stall_o, 0);
  endtask

  initial begin
    bit [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    chk("rst_rvalid_err", {mem_rvalid_o, mem_err_o}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from the requirements list
    run_txn(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    run_txn(0, 0, 3'd0, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0, 0, 0, 0);
    run_txn(0, 0, 3'd4, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0, 0, 0, 0);
    run_txn(1, 0, 3'd1, 32'h102, 32'h1234, 0, 0, 0, 0, 3, 0, 0);
    run_txn(0, 0, 3'd2, 32'h101, 0, 32'h12345678, 0, 0, 0, 0, 0, 0);
    run_txn(0, 0, 3'd2, 32'h180, 0, 32'h11111111, 2'b10, 0, 0, 0, 0, 0);
    run_txn(1, 1, 3'd0, 32'h2A1, 32'hCAFE_00A5, 2'b11, 0, 0, 0, 2, 1, 0);

    for (int i = 0; i < 80; i++) begin
      a = ($urandom & 32'h0000_FFFC) | (($urandom % 2) ? ($urandom % 4) : 0);
      run_txn($urandom % 2, $urandom % 2, 3'($urandom % 8), a, $urandom, $urandom,
              ($urandom % 5 == 0) ? 2'($urandom % 4) : 2'b00,
              $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4);
    end

    // Reset while a load sits in RD_DATA
    mem_ren_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h200; arready_i = 1'b1;
    @(posedge clk); #1;
    mem_ren_i = 1'b0;
    @(posedge clk); #1;
    arready_i = 1'b0;
    chk("rst_pre_rready", rready_o, 1);
    chk("rst_pre_araddr", araddr_o, 32'h200);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rready", rready_o, 0);
    chk("rst_mid_arvalid", arvalid_o, 0);
    chk("rst_mid_stall", mem_stall_o, 0);
    chk("rst_mid_araddr", araddr_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a store waits in WR_REQ
    mem_wen_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h300; mem_wdata_i = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_wen_i = 1'b0;
    chk("rst_pre_awvalid", awvalid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_aw_w", {awvalid_o, wvalid_o, bready_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 0, 3'd5, 32'h402, 0, 32'hF00D_8001, 0, 1, 2, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
